// File: rtl/register_file_pkg.sv
// Shared constants and types for the architectural register file.
// ROB_WIDTH_BIT sets the default ROB tag width; REG_NUM is the number of
// architectural registers; the ROB type codes are shared with the ROB.
package register_file_pkg;

    localparam int unsigned ROB_WIDTH_BIT = 4;
    localparam int unsigned REG_NUM       = 32;
    localparam int unsigned REG_ID_W      = 5;
    localparam int unsigned DATA_W        = 32;
    localparam int unsigned READ_PORTS    = 2;

    // Entry kinds tracked by the ROB.
    typedef enum logic [1:0] {
        ROB_TYPE_REG    = 2'd0,
        ROB_TYPE_STORE  = 2'd1,
        ROB_TYPE_BRANCH = 2'd2,
        ROB_TYPE_EXIT   = 2'd3
    } rob_type_e;

    // Operand as delivered to the decoder.
    typedef struct packed {
        logic [DATA_W-1:0]        val;
        logic                     has_dep;
        logic [ROB_WIDTH_BIT-1:0] dep;
    } operand_t;

endpackage

// File: rtl/register_file.sv
// Architectural register file with rename tags.
// Writes: ROB commit port (set_reg_*) and rename port (set_dep_*), applied on
// posedge clk_in only while rdy_in=1; priority clear > rename > commit-clears-busy.
// Reads: two combinational decoder ports, each returning a value or the ROB tag
// it is still waiting on; pending tags are resolved via the ROB lookup ports.
// Ports:
//   clk_in, rst_in (async, active-low), rdy_in (pause), clear (ROB flush)
//   set_reg_id/set_val/set_reg_on_rob_id   commit destination, value, tag
//   set_dep_reg_id/set_dep_rob_id          rename destination and its tag
//   get_id1/2 -> val1/2, has_dep1/2, dep1/2, get_rob_id1/2
//   rob_value1/2_ready, rob_value1/2       ROB lookup result for get_rob_id1/2
// Configuration: define REGFILE_COMMIT_BYPASS_EN to forward the committing value
// straight to a matching read port during the commit cycle.
module register_file
    import register_file_pkg::*;
#(
    parameter int unsigned ROB_SIZE_BIT = ROB_WIDTH_BIT,
    parameter int unsigned REG_NUM      = register_file_pkg::REG_NUM
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    clear,
    input  logic [REG_ID_W-1:0]     set_reg_id,
    input  logic [DATA_W-1:0]       set_val,
    input  logic [ROB_SIZE_BIT-1:0] set_reg_on_rob_id,
    input  logic [REG_ID_W-1:0]     set_dep_reg_id,
    input  logic [ROB_SIZE_BIT-1:0] set_dep_rob_id,
    input  logic [REG_ID_W-1:0]     get_id1,
    input  logic [REG_ID_W-1:0]     get_id2,
    output logic [DATA_W-1:0]       val1,
    output logic [DATA_W-1:0]       val2,
    output logic                    has_dep1,
    output logic                    has_dep2,
    output logic [ROB_SIZE_BIT-1:0] dep1,
    output logic [ROB_SIZE_BIT-1:0] dep2,
    output logic [ROB_SIZE_BIT-1:0] get_rob_id1,
    output logic [ROB_SIZE_BIT-1:0] get_rob_id2,
    input  logic                    rob_value1_ready,
    input  logic                    rob_value2_ready,
    input  logic [DATA_W-1:0]       rob_value1,
    input  logic [DATA_W-1:0]       rob_value2
);

    logic [DATA_W-1:0]       regs [REG_NUM];
    logic [ROB_SIZE_BIT-1:0] tag  [REG_NUM];
    logic [REG_NUM-1:0]      busy;

    logic commit_en;
    logic rename_en;

    assign commit_en = rdy_in && !clear && (set_reg_id != '0);
    assign rename_en = rdy_in && !clear && (set_dep_reg_id != '0);

    // State update; x0 is excluded from the loop so it stays zero and never busy.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < int'(REG_NUM); i++) begin
                regs[i] <= '0;
                tag[i]  <= '0;
            end
            busy <= '0;
        end else if (rdy_in) begin
            if (clear) begin
                for (int i = 0; i < int'(REG_NUM); i++) begin
                    tag[i] <= '0;
                end
                busy <= '0;
            end else begin
                for (int i = 1; i < int'(REG_NUM); i++) begin
                    if (commit_en && (set_reg_id == REG_ID_W'(i))) begin
                        regs[i] <= set_val;
                    end
                    // A same-cycle rename supersedes the commit's busy clear.
                    if (rename_en && (set_dep_reg_id == REG_ID_W'(i))) begin
                        busy[i] <= 1'b1;
                        tag[i]  <= set_dep_rob_id;
                    end else if (commit_en && (set_reg_id == REG_ID_W'(i)) &&
                                 busy[i] && (tag[i] == set_reg_on_rob_id)) begin
                        busy[i] <= 1'b0;
                    end
                end
            end
        end
    end

    logic [REG_ID_W-1:0] get_id_a    [READ_PORTS];
    logic                rob_ready_a [READ_PORTS];
    logic [DATA_W-1:0]   rob_value_a [READ_PORTS];

    assign get_id_a[0]    = get_id1;
    assign get_id_a[1]    = get_id2;
    assign rob_ready_a[0] = rob_value1_ready;
    assign rob_ready_a[1] = rob_value2_ready;
    assign rob_value_a[0] = rob_value1;
    assign rob_value_a[1] = rob_value2;

    // Per-port operand mux: architectural value, ROB bypass, or pending tag.
    for (genvar k = 0; k < int'(READ_PORTS); k++) begin : g_rd
        logic [DATA_W-1:0]       val_c;
        logic                    has_dep_c;
        logic [ROB_SIZE_BIT-1:0] dep_c;
        logic [ROB_SIZE_BIT-1:0] tag_c;

        assign tag_c = tag[get_id_a[k]];

        always_comb begin
            val_c     = regs[get_id_a[k]];
            has_dep_c = 1'b0;
            dep_c     = '0;
            if ((get_id_a[k] != '0) && busy[get_id_a[k]]) begin
`ifdef REGFILE_COMMIT_BYPASS_EN
                if (!clear && (set_reg_id != '0) && (get_id_a[k] == set_reg_id) &&
                    (tag_c == set_reg_on_rob_id)) begin
                    val_c = set_val;
                end else
`endif
                if (rob_ready_a[k]) begin
                    val_c = rob_value_a[k];
                end else begin
                    val_c     = '0;
                    has_dep_c = 1'b1;
                    dep_c     = tag_c;
                end
            end
        end
    end

    assign val1        = g_rd[0].val_c;
    assign has_dep1    = g_rd[0].has_dep_c;
    assign dep1        = g_rd[0].dep_c;
    assign get_rob_id1 = g_rd[0].tag_c;
    assign val2        = g_rd[1].val_c;
    assign has_dep2    = g_rd[1].has_dep_c;
    assign dep2        = g_rd[1].dep_c;
    assign get_rob_id2 = g_rd[1].tag_c;

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file (default 4-bit ROB tags).
module tb_register_file;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clear;
    logic [4:0]  set_reg_id;
    logic [31:0] set_val;
    logic [3:0]  set_reg_on_rob_id;
    logic [4:0]  set_dep_reg_id;
    logic [3:0]  set_dep_rob_id;
    logic [4:0]  get_id1, get_id2;
    logic [31:0] val1, val2;
    logic        has_dep1, has_dep2;
    logic [3:0]  dep1, dep2;
    logic [3:0]  get_rob_id1, get_rob_id2;
    logic        rob_value1_ready, rob_value2_ready;
    logic [31:0] rob_value1, rob_value2;

    int tests  = 0;
    int failed = 0;

    register_file dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .rdy_in            (rdy_in),
        .clear             (clear),
        .set_reg_id        (set_reg_id),
        .set_val           (set_val),
        .set_reg_on_rob_id (set_reg_on_rob_id),
        .set_dep_reg_id    (set_dep_reg_id),
        .set_dep_rob_id    (set_dep_rob_id),
        .get_id1           (get_id1),
        .get_id2           (get_id2),
        .val1              (val1),
        .val2              (val2),
        .has_dep1          (has_dep1),
        .has_dep2          (has_dep2),
        .dep1              (dep1),
        .dep2              (dep2),
        .get_rob_id1       (get_rob_id1),
        .get_rob_id2       (get_rob_id2),
        .rob_value1_ready  (rob_value1_ready),
        .rob_value2_ready  (rob_value2_ready),
        .rob_value1        (rob_value1),
        .rob_value2        (rob_value2)
    );

    always #5 clk_in = ~clk_in;

    task automatic idle();
        rdy_in            = 1'b1;
        clear             = 1'b0;
        set_reg_id        = '0;
        set_val           = '0;
        set_reg_on_rob_id = '0;
        set_dep_reg_id    = '0;
        set_dep_rob_id    = '0;
        rob_value1_ready  = 1'b0;
        rob_value2_ready  = 1'b0;
        rob_value1        = '0;
        rob_value2        = '0;
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        idle();
        get_id1 = 5'd5;
        get_id2 = 5'd0;
        #2;
        tests++;
        if (val1 !== 32'd0 || has_dep1 !== 1'b0 || dep1 !== 4'd0 || get_rob_id1 !== 4'd0) begin
            failed++;
            $display("FAIL reset_port1 val=%h has_dep=%b dep=%0d rob_id=%0d, want 0/0/0/0",
                     val1, has_dep1, dep1, get_rob_id1);
        end
        step();
        rst_in = 1'b1;
        step();
    endtask

    task automatic test_rename_dep();
        idle();
        set_dep_reg_id = 5'd3;
        set_dep_rob_id = 4'd2;
        get_id1 = 5'd3;
        #1;
        tests++;
        if (has_dep1 !== 1'b0) begin
            failed++;
            $display("FAIL rename_same_cycle has_dep1=%b, want 0", has_dep1);
        end
        step();
        idle();
        get_id1 = 5'd3;
        #1;
        tests++;
        if (has_dep1 !== 1'b1 || dep1 !== 4'd2 || get_rob_id1 !== 4'd2 || val1 !== 32'd0) begin
            failed++;
            $display("FAIL rename_dep has_dep=%b dep=%0d rob_id=%0d val=%h, want 1/2/2/0",
                     has_dep1, dep1, get_rob_id1, val1);
        end
    endtask

    task automatic test_rob_bypass();
        idle();
        get_id1 = 5'd3;
        get_id2 = 5'd3;
        rob_value1_ready = 1'b1;
        rob_value1 = 32'hDEAD;
        #1;
        tests++;
        if (val1 !== 32'hDEAD || has_dep1 !== 1'b0 || dep1 !== 4'd0) begin
            failed++;
            $display("FAIL rob_bypass val=%h has_dep=%b dep=%0d, want dead/0/0", val1, has_dep1, dep1);
        end
        tests++;
        if (has_dep2 !== 1'b1 || dep2 !== 4'd2 || get_rob_id2 !== 4'd2) begin
            failed++;
            $display("FAIL port2_pending has_dep=%b dep=%0d rob_id=%0d, want 1/2/2",
                     has_dep2, dep2, get_rob_id2);
        end
    endtask

    task automatic test_commit_rename_same();
        idle();
        set_reg_id = 5'd3;
        set_val = 32'h11;
        set_reg_on_rob_id = 4'd2;
        set_dep_reg_id = 5'd3;
        set_dep_rob_id = 4'd5;
        step();
        idle();
        get_id1 = 5'd3;
        #1;
        tests++;
        if (has_dep1 !== 1'b1 || dep1 !== 4'd5) begin
            failed++;
            $display("FAIL commit_vs_rename has_dep=%b dep=%0d, want 1/5", has_dep1, dep1);
        end
    endtask

    task automatic test_stale_commit();
        idle();
        set_reg_id = 5'd3;
        set_val = 32'h22;
        set_reg_on_rob_id = 4'd2;
        get_id1 = 5'd3;
        #1;
        tests++;
        if (has_dep1 !== 1'b1 || dep1 !== 4'd5) begin
            failed++;
            $display("FAIL stale_commit_cycle has_dep=%b dep=%0d, want 1/5", has_dep1, dep1);
        end
        step();
        idle();
        get_id1 = 5'd3;
        #1;
        tests++;
        if (has_dep1 !== 1'b1 || dep1 !== 4'd5) begin
            failed++;
            $display("FAIL stale_commit_after has_dep=%b dep=%0d, want 1/5", has_dep1, dep1);
        end
    endtask

    task automatic test_clear();
        idle();
        set_reg_id = 5'd1;
        set_val = 32'hAA1;
        step();
        idle();
        set_dep_reg_id = 5'd1;
        set_dep_rob_id = 4'd7;
        step();
        idle();
        set_dep_reg_id = 5'd7;
        set_dep_rob_id = 4'd8;
        step();
        idle();
        get_id1 = 5'd1;
        get_id2 = 5'd7;
        #1;
        tests++;
        if (has_dep1 !== 1'b1 || dep1 !== 4'd7 || has_dep2 !== 1'b1 || dep2 !== 4'd8) begin
            failed++;
            $display("FAIL clear_setup dep1=%b/%0d dep2=%b/%0d, want 1/7 1/8",
                     has_dep1, dep1, has_dep2, dep2);
        end
        clear = 1'b1;
        set_reg_id = 5'd1;
        set_val = 32'hBAD;
        set_reg_on_rob_id = 4'd7;
        set_dep_reg_id = 5'd9;
        set_dep_rob_id = 4'd3;
        step();
        idle();
        get_id1 = 5'd1;
        get_id2 = 5'd7;
        #1;
        tests++;
        if (val1 !== 32'hAA1 || has_dep1 !== 1'b0 || dep1 !== 4'd0 || get_rob_id1 !== 4'd0) begin
            failed++;
            $display("FAIL clear_x1 val=%h has_dep=%b dep=%0d rob_id=%0d, want aa1/0/0/0",
                     val1, has_dep1, dep1, get_rob_id1);
        end
        tests++;
        if (val2 !== 32'd0 || has_dep2 !== 1'b0) begin
            failed++;
            $display("FAIL clear_x7 val=%h has_dep=%b, want 0/0", val2, has_dep2);
        end
        get_id1 = 5'd9;
        get_id2 = 5'd3;
        #1;
        tests++;
        if (has_dep1 !== 1'b0 || get_rob_id1 !== 4'd0) begin
            failed++;
            $display("FAIL clear_ignores_rename has_dep=%b rob_id=%0d, want 0/0", has_dep1, get_rob_id1);
        end
        tests++;
        if (val2 !== 32'h22 || has_dep2 !== 1'b0) begin
            failed++;
            $display("FAIL clear_x3_stale_value val=%h has_dep=%b, want 22/0", val2, has_dep2);
        end
        get_id1 = 5'd0;
        #1;
        tests++;
        if (val1 !== 32'd0 || has_dep1 !== 1'b0) begin
            failed++;
            $display("FAIL x0_read val=%h has_dep=%b, want 0/0", val1, has_dep1);
        end
    endtask

    task automatic test_commit_clears_busy();
        idle();
        set_dep_reg_id = 5'd4;
        set_dep_rob_id = 4'd15;
        step();
        idle();
        set_reg_id = 5'd4;
        set_val = 32'h44;
        set_reg_on_rob_id = 4'd15;
        step();
        idle();
        get_id1 = 5'd4;
        #1;
        tests++;
        if (val1 !== 32'h44 || has_dep1 !== 1'b0 || dep1 !== 4'd0) begin
            failed++;
            $display("FAIL commit_clears_busy val=%h has_dep=%b dep=%0d, want 44/0/0",
                     val1, has_dep1, dep1);
        end
    endtask

    task automatic test_rdy_low();
        idle();
        rdy_in = 1'b0;
        set_dep_reg_id = 5'd2;
        set_dep_rob_id = 4'd9;
        step();
        set_dep_reg_id = '0;
        set_reg_id = 5'd2;
        set_val = 32'h55;
        step();
        set_reg_id = '0;
        get_id1 = 5'd2;
        get_id2 = 5'd4;
        #1;
        tests++;
        if (val1 !== 32'd0 || has_dep1 !== 1'b0 || get_rob_id1 !== 4'd0) begin
            failed++;
            $display("FAIL rdy_low_frozen val=%h has_dep=%b rob_id=%0d, want 0/0/0",
                     val1, has_dep1, get_rob_id1);
        end
        tests++;
        if (val2 !== 32'h44) begin
            failed++;
            $display("FAIL rdy_low_read_live val=%h, want 44", val2);
        end
        idle();
    endtask

    task automatic test_async_reset();
        idle();
        set_dep_reg_id = 5'd5;
        set_dep_rob_id = 4'd1;
        step();
        idle();
        get_id1 = 5'd5;
        get_id2 = 5'd4;
        #1;
        tests++;
        if (has_dep1 !== 1'b1 || dep1 !== 4'd1) begin
            failed++;
            $display("FAIL async_setup has_dep=%b dep=%0d, want 1/1", has_dep1, dep1);
        end
        #1;
        rst_in = 1'b0;
        #1;
        tests++;
        if (val1 !== 32'd0 || has_dep1 !== 1'b0 || dep1 !== 4'd0 || get_rob_id1 !== 4'd0 ||
            val2 !== 32'd0) begin
            failed++;
            $display("FAIL async_reset val1=%h has_dep=%b dep=%0d rob_id=%0d val2=%h, want all 0",
                     val1, has_dep1, dep1, get_rob_id1, val2);
        end
        step();
        rst_in = 1'b1;
        step();
    endtask

    initial begin
        get_id1 = '0;
        get_id2 = '0;
        test_reset();
        test_rename_dep();
        test_rob_bypass();
        test_commit_rename_same();
        test_stale_commit();
        test_clear();
        test_commit_clears_busy();
        test_rdy_low();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
